// File: rtl/resp_packer.sv
// Response packer: serialises ALU results and register reads into FIFO bytes.
// Ports: CLK/RST, Rd_D(+Valid), ALU_OUT(+Valid), F_FULL in; W_INC, TX_P_DATA, busy, drop_err out.
module resp_packer #(
    parameter int DATA_WIDTH = 8,
    parameter bit CHK_EN     = 1'b0
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [DATA_WIDTH-1:0]   Rd_D,
    input  logic                    Rd_D_Valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
    input  logic                    ALU_OUT_Valid,
    input  logic                    F_FULL,
    output logic                    W_INC,
    output logic [DATA_WIDTH-1:0]   TX_P_DATA,
    output logic                    busy,
    output logic                    drop_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        CHK  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [2*DATA_WIDTH-1:0] hold;
    logic [2*DATA_WIDTH-1:0] hold_nxt;
    logic [1:0]              cnt;
    logic [1:0]              cnt_nxt;
    logic [DATA_WIDTH-1:0]   chk;
    logic [DATA_WIDTH-1:0]   chk_nxt;
    logic                    drop_nxt;
    logic                    wr;

    // A byte leaves whenever a frame is active and the FIFO has room.
    assign wr = (state != IDLE) && !F_FULL;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            hold     <= '0;
            cnt      <= '0;
            chk      <= '0;
            drop_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold     <= hold_nxt;
            cnt      <= cnt_nxt;
            chk      <= chk_nxt;
            drop_err <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        cnt_nxt   = cnt;
        chk_nxt   = chk;
        unique case (state)
            IDLE: begin
                if (ALU_OUT_Valid) begin
                    hold_nxt  = ALU_OUT;
                    cnt_nxt   = 2'd2;
                    chk_nxt   = '0;
                    state_nxt = SEND;
                end else if (Rd_D_Valid) begin
                    hold_nxt  = {{DATA_WIDTH{1'b0}}, Rd_D};
                    cnt_nxt   = 2'd1;
                    chk_nxt   = '0;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (wr) begin
                    hold_nxt = hold >> DATA_WIDTH;
                    chk_nxt  = chk ^ hold[DATA_WIDTH-1:0];
                    cnt_nxt  = cnt - 2'd1;
                    if (cnt == 2'd1)
                        state_nxt = CHK_EN ? CHK : IDLE;
                end
            end
            CHK: begin
                if (wr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Idle: only a simultaneous pair loses the read. Busy: everything is lost.
    always_comb begin
        if (state == IDLE)
            drop_nxt = Rd_D_Valid && ALU_OUT_Valid;
        else
            drop_nxt = Rd_D_Valid || ALU_OUT_Valid;
    end

    always_comb begin
        W_INC     = wr && !RST;
        busy      = (state != IDLE);
        TX_P_DATA = '0;
        unique case (state)
            SEND:    TX_P_DATA = hold[DATA_WIDTH-1:0];
            CHK:     TX_P_DATA = chk;
            default: TX_P_DATA = '0;
        endcase
    end

endmodule

// File: tb/tb_resp_packer.sv
// Bench for resp_packer: two instances (checksum off/on) share stimulus,
// each compared per cycle against a frame-level byte-list model.
module tb_resp_packer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  Rd_D = '0;
    logic        Rd_D_Valid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_Valid = 1'b0;
    logic        F_FULL = 1'b0;

    logic        w0, w1, b0, b1, d0, d1;
    logic [7:0]  tx0, tx1;

    int errors = 0;
    int checks = 0;

    // model: current frame bytes, length, and how many already written
    logic [7:0] mb [2][3];
    int         mlen [2];
    int         mpos [2];
    logic       mdrop [2];

    always #5 CLK = ~CLK;

    resp_packer #(.DATA_WIDTH(8), .CHK_EN(1'b0)) u_dut0 (
        .CLK(CLK), .RST(RST),
        .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
        .F_FULL(F_FULL),
        .W_INC(w0), .TX_P_DATA(tx0),
        .busy(b0), .drop_err(d0)
    );

    resp_packer #(.DATA_WIDTH(8), .CHK_EN(1'b1)) u_dut1 (
        .CLK(CLK), .RST(RST),
        .Rd_D(Rd_D), .Rd_D_Valid(Rd_D_Valid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
        .F_FULL(F_FULL),
        .W_INC(w1), .TX_P_DATA(tx1),
        .busy(b1), .drop_err(d1)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t got=%h exp=%h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_dut(input int e, input logic w, input logic [7:0] tx,
                             input logic b, input logic d);
        bit   active;
        logic ew;
        active = (mpos[e] < mlen[e]);
        ew     = active && !F_FULL && !RST;
        check($sformatf("w_inc%0d", e), {15'd0, w}, {15'd0, ew});
        check($sformatf("busy%0d", e), {15'd0, b}, {15'd0, active});
        check($sformatf("drop%0d", e), {15'd0, d}, {15'd0, mdrop[e]});
        if (ew)
            check($sformatf("data%0d", e), {8'd0, tx}, {8'd0, mb[e][mpos[e]]});
        else if (!active)
            check($sformatf("idle_data%0d", e), {8'd0, tx}, 16'd0);
    endtask

    // Apply the edge's effect to one model instance.
    task automatic model_edge(input int e);
        bit active;
        active = (mpos[e] < mlen[e]);
        if (RST) begin
            mlen[e]  = 0;
            mpos[e]  = 0;
            mdrop[e] = 1'b0;
        end else begin
            mdrop[e] = active ? (Rd_D_Valid || ALU_OUT_Valid)
                              : (Rd_D_Valid && ALU_OUT_Valid);
            if (active) begin
                if (!F_FULL)
                    mpos[e]++;
            end else if (ALU_OUT_Valid) begin
                mb[e][0] = ALU_OUT[7:0];
                mb[e][1] = ALU_OUT[15:8];
                mb[e][2] = ALU_OUT[7:0] ^ ALU_OUT[15:8];
                mlen[e]  = (e == 1) ? 3 : 2;
                mpos[e]  = 0;
            end else if (Rd_D_Valid) begin
                mb[e][0] = Rd_D;
                mb[e][1] = Rd_D;
                mlen[e]  = (e == 1) ? 2 : 1;
                mpos[e]  = 0;
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic rdv, input logic [7:0] rd,
                       input logic aluv, input logic [15:0] alu,
                       input logic ff);
        RST           = rst;
        Rd_D_Valid    = rdv;
        Rd_D          = rd;
        ALU_OUT_Valid = aluv;
        ALU_OUT       = alu;
        F_FULL        = ff;
        @(negedge CLK);
        check_dut(0, w0, tx0, b0, d0);
        check_dut(1, w1, tx1, b1, d1);
        model_edge(0);
        model_edge(1);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        for (int e = 0; e < 2; e++) begin
            mlen[e]  = 0;
            mpos[e]  = 0;
            mdrop[e] = 1'b0;
        end
        @(posedge CLK);
        #1;
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        idle(2);

        // single read
        cyc(1'b0, 1'b1, 8'h5A, 1'b0, 16'h0000, 1'b0);
        idle(3);

        // ALU result, checksum 0x26 on the checked instance
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 1'b0);
        idle(4);

        // back-pressure for five cycles after acceptance
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1);
        idle(4);

        // simultaneous read and ALU: ALU wins
        cyc(1'b0, 1'b1, 8'h77, 1'b1, 16'h00C3, 1'b0);
        idle(4);

        // read arriving while busy is dropped
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 16'hABCD, 1'b0);
        cyc(1'b0, 1'b1, 8'h99, 1'b0, 16'h0000, 1'b0);
        idle(4);

        // reset in the high-byte cycle
        cyc(1'b0, 1'b0, 8'h00, 1'b1, 16'h5566, 1'b0);
        idle(1);
        cyc(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 8'h01, 1'b0, 16'h0000, 1'b0);
        idle(4);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) == 0), 8'($urandom),
                ($urandom_range(0, 3) == 0), 16'($urandom),
                ($urandom_range(0, 3) == 0));
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/resp_packer.md
# resp_packer

Response packer between the command path (register-file read data and ALU result, both in the REF_CLK domain) and the write side of the UART TX async FIFO. It captures one response per request, serialises it into FIFO bytes (ALU result low byte first, then high byte; register read as one byte), and optionally appends an XOR checksum. FIFO back-pressure via `F_FULL` is honoured. Responses arriving while a previous one is still draining are dropped and flagged.

## Interface
- `DATA_WIDTH`, default 8: byte width; ALU result width is `2*DATA_WIDTH`.
- `CHK_EN`, default 0: when 1, append a checksum byte (XOR of all payload bytes) after each response.

Ports:
- `CLK` in 1: REF_CLK-domain clock. Single clock; all state on rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Rd_D` in DATA_WIDTH: register-file read data.
- `Rd_D_Valid` in 1: single-cycle qualifier for `Rd_D`.
- `ALU_OUT` in 2*DATA_WIDTH: ALU result.
- `ALU_OUT_Valid` in 1: single-cycle qualifier for `ALU_OUT`.
- `F_FULL` in 1: FIFO full; no write may be issued while high.
- `W_INC` out 1: FIFO write strobe, one byte per high cycle.
- `TX_P_DATA` out DATA_WIDTH: FIFO write data, valid whenever `W_INC`=1.
- `busy` out 1: response in progress; new inputs are not accepted.
- `drop_err` out 1: one-cycle pulse, a valid input was discarded.

## Operation
- States: IDLE, SEND, CHK.
- Holding registers:
  - `hold` (2*DATA_WIDTH).
  - `cnt` (2 bits): bytes remaining in payload.
  - `chk` (DATA_WIDTH): running XOR.
- IDLE:
  - `ALU_OUT_Valid`=1: `hold`<=ALU_OUT, `cnt`<=2, `chk`<=0, go SEND.
  - Else `Rd_D_Valid`=1: `hold`<={0,Rd_D}, `cnt`<=1, `chk`<=0, go SEND.
  - Both valid in the same cycle: ALU wins, read byte is dropped, `drop_err` pulses.
- SEND:
  - `TX_P_DATA`=`hold[DATA_WIDTH-1:0]`; `W_INC`=!F_FULL.
  - On a write: `hold`<=hold>>DATA_WIDTH, `chk`<=chk^byte, `cnt`<=cnt-1.
  - Write with `cnt`=1: go CHK if CHK_EN=1, else IDLE.
  - `F_FULL`=1: stall with no state change; hold indefinitely.
- CHK:
  - `TX_P_DATA`=`chk`; `W_INC`=!F_FULL.
  - On the write: go IDLE. Stalls on `F_FULL` like SEND.
- `busy` = (state != IDLE).
- Any valid input seen while `busy`=1 is discarded and `drop_err` pulses; state and `hold` are unaffected.
- `TX_P_DATA` is 0 in IDLE.

## Timing
- Reset values: state IDLE; `hold`, `cnt`, `chk` = 0; `W_INC`=0, `TX_P_DATA`=0, `busy`=0, `drop_err`=0.
- `W_INC` is a combinational decode of state and `F_FULL`, gated low while `RST`=1. A reset asserted mid-response therefore issues no write in the reset cycle and discards the rest of the frame.
- Latency: input valid sampled at edge N; first `W_INC` is in cycle N+1 if `F_FULL`=0.
- With no back-pressure:
  - ALU response: writes in N+1 and N+2; with CHK_EN, checksum in N+3.
  - Read response: write in N+1; with CHK_EN, checksum in N+2.
- `busy` rises in cycle N+1. It falls the cycle after the last write. The earliest accepted next input is sampled in the cycle where `busy`=0.
- `drop_err` is registered: high for exactly the cycle after the dropped input.
- Each `F_FULL` cycle during SEND/CHK adds exactly one cycle; byte order is never altered.
- `F_FULL` is sampled combinationally each cycle. Deassertion allows a write in that same cycle.

## Test plan
- Read path, CHK_EN=0: Rd_D=0x5A pulse → one `W_INC` at N+1 with TX_P_DATA=0x5A; `busy` high for 1 cycle.
- ALU path, CHK_EN=1: ALU_OUT=0x1234 → writes 0x34, 0x12, then 0x26 in three consecutive cycles; `busy` low afterwards.
- Back-pressure: ALU_OUT=0xBEEF with F_FULL held high for 5 cycles after acceptance → no `W_INC` during stall. Then 0xEF and 0xBE are written in the first two cycles after F_FULL falls.
- Collisions:
  - Rd_D_Valid and ALU_OUT_Valid asserted together (0x77, 0x00C3) → only 0xC3, 0x00 written; `drop_err` pulses once.
  - A second Rd_D_Valid during `busy` → dropped, `drop_err` pulse, frame intact.
- Reset mid-frame: RST asserted in the cycle the ALU high byte would be written → no `W_INC` in that cycle; all outputs 0 after the edge; a subsequent Rd_D=0x01 is packed normally.
